// File: rtl/mem_col_argmax_if.sv
// Stream interface for mem_col_argmax: tagged current beats in, argmax result out.
// Both directions use valid/ready; the master is the upstream/consumer side.
interface mem_col_argmax_if #(
    parameter int IW    = 35,
    parameter int ACC_W = 48,
    parameter int CLS_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [IW-1:0]    in_I;
    logic [CLS_W-1:0] in_cls;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [CLS_W-1:0] out_class;
    logic [ACC_W-1:0] out_score;
    logic             out_sat;
    logic             out_err;

    modport master (
        output in_valid, in_I, in_cls, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_score, out_sat, out_err
    );

    modport slave (
        input  in_valid, in_I, in_cls, in_last, out_ready,
        output in_ready, out_valid, out_class, out_score, out_sat, out_err
    );
endinterface

// File: rtl/mem_col_argmax.sv
// Per-class saturating column-current accumulator with a frame-end argmax scan.
// in_I and out_score are two's-complement values carried on plain logic vectors.
module mem_col_argmax #(
    parameter int IW    = 35,
    parameter int ACC_W = 48,
    parameter int NCLS  = 6,
    parameter int CLS_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    mem_col_argmax_if.slave  io
);
    typedef enum logic [1:0] {ACCUM, SCAN, DONE} state_t;

    localparam logic [CLS_W:0] NCLS_W = (CLS_W+1)'(NCLS);

    state_t                  state_reg;
    logic                    in_ready_reg;
    logic                    out_valid_reg;
    logic [CLS_W-1:0]        out_class_reg;
    logic signed [ACC_W-1:0] out_score_reg;
    logic                    out_sat_reg;
    logic                    out_err_reg;
    logic                    sat_reg;
    logic                    err_reg;
    logic [CLS_W:0]          scan_k_reg;
    logic signed [ACC_W-1:0] rd_reg;
    logic [CLS_W-1:0]        rd_idx_reg;
    logic signed [ACC_W-1:0] best_reg;
    logic [CLS_W-1:0]        best_idx_reg;

    logic signed [ACC_W-1:0] acc_val [NCLS];
    logic signed [ACC_W-1:0] sel_acc;
    logic signed [ACC_W-1:0] rd_sel;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] sum_sat;
    logic                    sum_ovf;
    logic                    accept;
    logic                    release_res;
    logic                    cls_ok;
    logic                    take;

    assign accept      = io.in_valid && in_ready_reg;
    assign release_res = (state_reg == DONE) && out_valid_reg && io.out_ready;
    assign cls_ok      = ({1'b0, io.in_cls} < NCLS_W);

    always_comb begin
        sel_acc = '0;
        for (int i = 0; i < NCLS; i++) begin
            if (io.in_cls == CLS_W'(i)) sel_acc = acc_val[i];
        end
    end

    // One guard bit above the accumulator catches overflow in either direction.
    assign sum_wide = {sel_acc[ACC_W-1], sel_acc}
                    + {{(ACC_W+1-IW){io.in_I[IW-1]}}, io.in_I};
    assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    always_comb begin
        sum_sat = sum_wide[ACC_W-1:0];
        if (sum_ovf) begin
            sum_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    for (genvar gi = 0; gi < NCLS; gi++) begin : g_acc
        logic signed [ACC_W-1:0] acc_reg;

        always_ff @(posedge clk) begin
            if (rst || release_res) begin
                acc_reg <= '0;
            end else if (accept && io.in_cls == CLS_W'(gi)) begin
                acc_reg <= sum_sat;
            end
        end

        assign acc_val[gi] = acc_reg;
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCLS; i++) begin
            if (scan_k_reg == (CLS_W+1)'(i)) rd_sel = acc_val[i];
        end
    end

    // The scan reads one accumulator per cycle into rd_reg and compares it a
    // cycle later; index 0 seeds the best, strict > keeps ties on the lower index.
    assign take = (rd_idx_reg == '0) || (rd_reg > best_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACCUM;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_class_reg <= '0;
            out_score_reg <= '0;
            out_sat_reg   <= 1'b0;
            out_err_reg   <= 1'b0;
            sat_reg       <= 1'b0;
            err_reg       <= 1'b0;
            scan_k_reg    <= '0;
            rd_reg        <= '0;
            rd_idx_reg    <= '0;
            best_reg      <= '0;
            best_idx_reg  <= '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        if (!cls_ok) begin
                            err_reg <= 1'b1;
                        end else if (sum_ovf) begin
                            sat_reg <= 1'b1;
                        end
                        if (io.in_last) begin
                            state_reg    <= SCAN;
                            in_ready_reg <= 1'b0;
                            scan_k_reg   <= '0;
                        end
                    end
                end

                SCAN: begin
                    if (scan_k_reg < NCLS_W) begin
                        rd_reg     <= rd_sel;
                        rd_idx_reg <= scan_k_reg[CLS_W-1:0];
                    end
                    if (scan_k_reg != '0 && take) begin
                        best_reg     <= rd_reg;
                        best_idx_reg <= rd_idx_reg;
                    end
                    if (scan_k_reg == NCLS_W) begin
                        out_class_reg <= take ? rd_idx_reg : best_idx_reg;
                        out_score_reg <= take ? rd_reg : best_reg;
                        out_sat_reg   <= sat_reg;
                        out_err_reg   <= err_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                    scan_k_reg <= scan_k_reg + 1'b1;
                end

                DONE: begin
                    if (release_res) begin
                        out_valid_reg <= 1'b0;
                        sat_reg       <= 1'b0;
                        err_reg       <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ACCUM;
                    end
                end

                default: begin
                    state_reg    <= ACCUM;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign io.in_ready  = in_ready_reg;
    assign io.out_valid = out_valid_reg;
    assign io.out_class = out_class_reg;
    assign io.out_score = out_score_reg;
    assign io.out_sat   = out_sat_reg;
    assign io.out_err   = out_err_reg;
endmodule
